iter_span_scanner: RTL and testbench



---
 rtl/iter_span_scanner.sv | 186 ++++++++++++++++++
 tb/tb_iter_span_scanner.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_span_scanner.sv
// iter_span_scanner: walks rows y_min..y_max (y_max clamped to the screen), requests a span
// [x0,x1] per row from an external span generator with LAT cycles of latency, clips the span
// to the screen and emits one pixel coordinate per cycle in which the consumer is ready.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               begin a scan (sampled only while idle)
//   abort_i               end the running scan at the next edge, no done pulse
//   oe_i                  downstream ready; low stalls the pixel walk
//   y_min_i, y_max_i      row range, latched on start
//   y_o                   current row, drives the span generator
//   x0_i, x1_i            span for y_o (inclusive), valid LAT cycles after y_o changes
//   x_o                   current pixel x
//   drawing_o             pixel (x_o,y_o) is transferred this cycle
//   busy_o                scan in progress
//   done_o                one-cycle pulse on normal completion
//   pix_cnt_o             pixels emitted in the current or most recent scan
module iter_span_scanner #(
  parameter int unsigned CORDW    = 10,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned LAT      = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               oe_i,
  input  logic [CORDW-1:0]   y_min_i,
  input  logic [CORDW-1:0]   y_max_i,
  output logic [CORDW-1:0]   y_o,
  input  logic [CORDW-1:0]   x0_i,
  input  logic [CORDW-1:0]   x1_i,
  output logic [CORDW-1:0]   x_o,
  output logic               drawing_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*CORDW-1:0] pix_cnt_o
);

  localparam logic [CORDW-1:0] YLast   = CORDW'(SCREEN_H - 1);
  localparam logic [CORDW-1:0] XLast   = CORDW'(SCREEN_W - 1);
  // One bit wider so a screen width of exactly 2^CORDW still compares correctly.
  localparam logic [CORDW:0]   XLimit  = (CORDW + 1)'(SCREEN_W);
  localparam logic [2:0]       LatLast = 3'((LAT == 0) ? 0 : LAT - 1);

  typedef enum logic [2:0] {StIdle, StWait, StSample, StDraw, StNext} state_e;

  state_e               state_q, state_d;
  state_e               row_entry;
  logic [CORDW-1:0]     y_q, y_d;
  logic [CORDW-1:0]     ye_q, ye_d;
  logic [CORDW-1:0]     x_q, x_d;
  logic [CORDW-1:0]     xe_q, xe_d;
  logic [2:0]           lat_q, lat_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*CORDW-1:0]   pix_q, pix_d;
  logic [CORDW-1:0]     ye_clamp;
  logic [CORDW-1:0]     xe_clip;
  logic                 row_empty;
  logic                 drawing;

  assign drawing   = (state_q == StDraw) && oe_i;
  assign ye_clamp  = (y_max_i > YLast) ? YLast : y_max_i;
  assign xe_clip   = (x1_i > XLast) ? XLast : x1_i;
  assign row_empty = (x0_i > x1_i) || ({1'b0, x0_i} >= XLimit);

  // With no generator latency the span is already valid the cycle after y changes.
  always_comb begin
    if (LAT == 0) begin
      row_entry = StSample;
    end else begin
      row_entry = StWait;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    ye_d    = ye_q;
    x_d     = x_q;
    xe_d    = xe_q;
    lat_d   = lat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pix_d   = pix_q;

    if (drawing) begin
      pix_d = pix_q + (2 * CORDW)'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          ye_d   = ye_clamp;
          y_d    = y_min_i;
          pix_d  = '0;
          busy_d = 1'b1;
          lat_d  = '0;
          // An empty range goes straight to NEXT, which ends the scan since y > ye.
          state_d = (y_min_i > ye_clamp) ? StNext : row_entry;
        end
      end
      StWait: begin
        if (lat_q == LatLast) begin
          state_d = StSample;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      StSample: begin
        if (row_empty) begin
          state_d = StNext;
        end else begin
          x_d     = x0_i;
          xe_d    = xe_clip;
          state_d = StDraw;
        end
      end
      StDraw: begin
        if (oe_i) begin
          if (x_q == xe_q) begin
            state_d = StNext;
          end else begin
            x_d = x_q + CORDW'(1);
          end
        end
      end
      StNext: begin
        // >= rather than == also terminates the empty-range case.
        if (y_q >= ye_q) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          y_d     = y_q + CORDW'(1);
          lat_d   = '0;
          state_d = row_entry;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort still counts a pixel transferred in the abort cycle itself.
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      x_d     = x_q;
      y_d     = y_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      y_q     <= '0;
      ye_q    <= '0;
      x_q     <= '0;
      xe_q    <= '0;
      lat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ye_q    <= ye_d;
      x_q     <= x_d;
      xe_q    <= xe_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pix_q   <= pix_d;
    end
  end

  assign y_o       = y_q;
  assign x_o       = x_q;
  assign drawing_o = drawing;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pix_cnt_o = pix_q;

endmodule

// File: tb/tb_iter_span_scanner.sv
// Testbench for iter_span_scanner: three instances (LAT = 1, 3, 0) each fed by a span generator
// built from per-row lookup tables delayed by that instance's latency. Expected pixels, counts
// and scan lengths come from walking the row range and clipping spans with plain arithmetic.
module tb_iter_span_scanner;

  localparam int CW = 10;
  localparam int N  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_s [N];
  logic            abort_s [N];
  logic            oe_s    [N];
  logic [CW-1:0]   ymin_s  [N];
  logic [CW-1:0]   ymax_s  [N];
  logic [CW-1:0]   x0_s    [N];
  logic [CW-1:0]   x1_s    [N];
  logic [CW-1:0]   y_s     [N];
  logic [CW-1:0]   x_s     [N];
  logic            draw_s  [N];
  logic            busy_s  [N];
  logic            done_s  [N];
  logic [2*CW-1:0] pix_s   [N];
  logic [CW-1:0]   tab_x0  [1024];
  logic [CW-1:0]   tab_x1  [1024];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 0);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : ((g == 1) ? 3 : 0);

    iter_span_scanner #(
      .CORDW(CW), .SCREEN_W(640), .SCREEN_H(480), .LAT(L)
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start_s[g]), .abort_i(abort_s[g]), .oe_i(oe_s[g]),
      .y_min_i(ymin_s[g]), .y_max_i(ymax_s[g]), .y_o(y_s[g]), .x0_i(x0_s[g]), .x1_i(x1_s[g]),
      .x_o(x_s[g]), .drawing_o(draw_s[g]), .busy_o(busy_s[g]), .done_o(done_s[g]),
      .pix_cnt_o(pix_s[g])
    );

    if (L == 0) begin : g_comb
      assign x0_s[g] = tab_x0[y_s[g]];
      assign x1_s[g] = tab_x1[y_s[g]];
    end else begin : g_pipe
      logic [CW-1:0] yd [L];
      always @(posedge clk) begin
        yd[0] <= y_s[g];
        for (int k = 1; k < int'(L); k++) yd[k] <= yd[k-1];
      end
      assign x0_s[g] = tab_x0[yd[L-1]];
      assign x1_s[g] = tab_x1[yd[L-1]];
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_row(input int r, input int a, input int b);
    tab_x0[r] = CW'(a);
    tab_x1[r] = CW'(b);
  endtask

  task automatic rand_rows(input int lo, input int hi);
    for (int r = lo; r <= hi && r < 1024; r++) begin
      int sel = $urandom_range(0, 5);
      int a = (sel < 2) ? $urandom_range(615, 660) : $urandom_range(0, 600);
      int b = a + $urandom_range(0, 12);
      if (sel == 5 && a > 0) b = a - 1;
      set_row(r, a, b);
    end
  endtask

  // oe_mode: 0 = always ready, 1 = random, 2 = fixed pattern (low on cycles 4 and 5).
  // abort_cyc > 0 pulses abort on that cycle. exp_pix/exp_cyc < 0 skip literal checks.
  task automatic run_scan(input int g, input int ymin, input int ymax, input int oe_mode,
                          input int abort_cyc, input int exp_pix, input int exp_cyc);
    int lat = lat_of(g);
    int ye = (ymax > 479) ? 479 : ymax;
    int qx[$];
    int qy[$];
    int total;
    int sum = 0;
    int popped = 0;
    bit fin = 0;

    if (ymin > ye) begin
      sum = 1;
    end else begin
      for (int r = ymin; r <= ye; r++) begin
        int a = int'(tab_x0[r]);
        int b = int'(tab_x1[r]);
        int w = 0;
        if (a <= b && a < 640) begin
          int e = (b > 639) ? 639 : b;
          for (int xx = a; xx <= e; xx++) begin
            qx.push_back(xx);
            qy.push_back(r);
          end
          w = e - a + 1;
        end
        sum += lat + 2 + w;
      end
    end
    total = qx.size();

    @(negedge clk);
    ymin_s[g] = CW'(ymin);
    ymax_s[g] = CW'(ymax);
    oe_s[g] = 1'b1;
    abort_s[g] = 1'b0;
    start_s[g] = 1'b1;
    @(negedge clk);
    start_s[g] = 1'b0;

    for (int cyc = 1; cyc <= 3000; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
        abort_s[g] = 1'b0;
        start_s[g] = 1'b0;
        chk("abort_busy", busy_s[g], 0);
        chk("abort_done", done_s[g], 0);
        chk("abort_pix_cnt", pix_s[g], popped);
        if (exp_pix >= 0) chk("abort_pix_lit", pix_s[g], exp_pix);
        fin = 1;
        break;
      end
      chk("pix_cnt_run", pix_s[g], popped);
      if (done_s[g]) begin
        start_s[g] = 1'b0;
        chk("done_busy", busy_s[g], 0);
        chk("done_pix_cnt", pix_s[g], total);
        chk("missing_pixels", qx.size(), 0);
        if (oe_mode == 0) chk("scan_cycles", cyc, sum + 1);
        if (exp_pix >= 0) chk("pix_lit", pix_s[g], exp_pix);
        if (exp_cyc > 0) chk("cycles_lit", cyc, exp_cyc);
        fin = 1;
        break;
      end
      chk("busy", busy_s[g], 1);
      // Start, y_min and y_max must be ignored while a scan runs.
      start_s[g] = ($urandom_range(0, 7) == 0);
      ymin_s[g] = CW'($urandom);
      ymax_s[g] = CW'($urandom);
      if (oe_mode == 0) oe_s[g] = 1'b1;
      else if (oe_mode == 1) oe_s[g] = ($urandom_range(0, 2) != 0);
      else oe_s[g] = !(cyc == 4 || cyc == 5);
      abort_s[g] = (cyc == abort_cyc);
      #1;
      if (draw_s[g]) begin
        if (qx.size() == 0) begin
          chk("extra_pixel", 1, 0);
        end else begin
          chk("pixel_x", x_s[g], qx.pop_front());
          chk("pixel_y", y_s[g], qy.pop_front());
          popped++;
        end
      end
      if (oe_mode == 2 && (cyc == 4 || cyc == 5)) chk("x_hold", x_s[g], 1);
    end

    start_s[g] = 1'b0;
    abort_s[g] = 1'b0;
    oe_s[g] = 1'b0;
    if (!fin) begin
      chk("scan_timeout", 0, 1);
    end else if (abort_cyc == 0) begin
      @(negedge clk);
      chk("done_one_cycle", done_s[g], 0);
      chk("idle_busy", busy_s[g], 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < N; g++) begin
      start_s[g] = 1'b0;
      abort_s[g] = 1'b0;
      oe_s[g] = 1'b0;
      ymin_s[g] = '0;
      ymax_s[g] = '0;
    end
    for (int r = 0; r < 1024; r++) set_row(r, 1, 0);
    repeat (2) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      chk("rst_busy", busy_s[g], 0);
      chk("rst_done", done_s[g], 0);
      chk("rst_xy", {x_s[g], y_s[g]}, 0);
      chk("rst_pix", pix_s[g], 0);
    end
    rst = 1'b0;

    // Basic three-row scan.
    for (int r = 2; r <= 4; r++) set_row(r, 5, 7);
    run_scan(0, 2, 4, 0, 0, 9, 19);

    // y_max clamped to the last screen row; empty range.
    for (int r = 10; r <= 479; r++) set_row(r, 0, 0);
    run_scan(0, 10, 600, 0, 0, 470, 1881);
    run_scan(0, 5, 3, 0, 0, 0, 2);

    // Clipped span, off-screen span, inverted span.
    set_row(20, 630, 700);
    set_row(21, 640, 650);
    set_row(22, 8, 3);
    run_scan(0, 20, 22, 0, 0, 10, 20);

    // Backpressure pattern on span 0..2.
    set_row(30, 0, 2);
    run_scan(0, 30, 30, 2, 0, 3, 9);

    // Distinct spans per row under LAT=3 and LAT=0.
    set_row(40, 1, 2);
    set_row(41, 3, 5);
    set_row(42, 6, 6);
    run_scan(1, 40, 42, 0, 0, 6, 22);
    run_scan(2, 40, 42, 0, 0, 6, 13);

    // Abort at x=4 of span 0..9.
    set_row(50, 0, 9);
    run_scan(0, 50, 50, 0, 7, 5, -1);

    // Abort and start together while idle: no scan.
    @(negedge clk);
    ymin_s[0] = 10'd50;
    ymax_s[0] = 10'd50;
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    chk("abort_start_idle", busy_s[0], 0);

    // Asynchronous reset in the middle of a row.
    start_s[0] = 1'b1;
    oe_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_x", x_s[0], 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy_s[0], 0);
    chk("arst_draw", draw_s[0], 0);
    chk("arst_xy", {x_s[0], y_s[0]}, 0);
    chk("arst_pix", pix_s[0], 0);
    chk("arst_done", done_s[0], 0);
    @(negedge clk);
    rst = 1'b0;
    oe_s[0] = 1'b0;

    // Randomized scans on every latency.
    for (int g = 0; g < N; g++) begin
      for (int n = 0; n < 8; n++) begin
        int ymin = $urandom_range(0, 490);
        int ymax = ymin + $urandom_range(0, 7);
        int sel = $urandom_range(0, 7);
        if (sel == 0) ymax = (ymin > 0) ? ymin - 1 : 0;
        if (sel == 1) begin
          ymin = $urandom_range(472, 479);
          ymax = 1023;
        end
        rand_rows(ymin, ymin + 8);
        run_scan(g, ymin, ymax, $urandom_range(0, 1), 0, -1, -1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
